// File: rtl/stall_ctrl.sv
// Central pipeline stall controller: load-use detection, multi-cycle EX op
// sequencing (req/ready with timeout) and merging of the memory-wait request.
//
// state | meaning
// IDLE  | no multi-cycle op in flight; launches when mc_req seen and memory ready
// BUSY  | multi-cycle unit working; pipeline held through EX
// DONE  | result available, EX op advances; held here while memory stalls
module stall_ctrl #(
  parameter int STALL_W    = 6,
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_mem,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic               id_rs_ren,
  input  logic               id_rt_ren,
  input  logic               ex_load,
  input  logic [4:0]         ex_waddr,
  input  logic               mc_req,
  input  logic               mc_ready,
  output logic [STALL_W-1:0] stall,
  output logic               mc_start,
  output logic               mc_busy,
  output logic               load_use,
  output logic               mc_timeout,
  output logic [CNT_W-1:0]   stall_cycles
);

  localparam int TMR_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MC_TIMEOUT - 1);

  localparam logic [STALL_W-1:0] STALL_MEM  = STALL_W'(6'b011111);
  localparam logic [STALL_W-1:0] STALL_MC   = STALL_W'(6'b001111);
  localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(6'b000111);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   stall_cycles_q;

  logic hazard;
  logic start;
  logic busy;
  logic mc_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      timeout_q      <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      if (stall != '0) stall_cycles_q <= stall_cycles_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    timeout_d = timeout_q;
    start     = 1'b0;
    busy      = 1'b0;
    mc_stall  = 1'b0;
    hazard    = ex_load && (ex_waddr != 5'd0) &&
                ((id_rs_ren && (id_rs == ex_waddr)) ||
                 (id_rt_ren && (id_rt == ex_waddr)));
    unique case (state_q)
      IDLE: begin
        if (mc_req && !stallreq_mem) begin
          start    = 1'b1;
          mc_stall = 1'b1;
          timer_d  = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        busy     = 1'b1;
        mc_stall = 1'b1;
        timer_d  = timer_q + TMR_W'(1);
        // A ready on the final timer cycle wins over the timeout.
        if (mc_ready) begin
          state_d = DONE;
        end else if (timer_q == TMR_LAST) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (!stallreq_mem) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, independent of inputs.
  always_comb begin
    stall = '0;
    if (rst) begin
      if (stallreq_mem)  stall = STALL_MEM;
      else if (mc_stall) stall = STALL_MC;
      else if (hazard)   stall = STALL_LOAD;
    end
  end

  assign mc_start     = rst & start;
  assign mc_busy      = rst & busy;
  assign load_use     = rst & hazard;
  assign mc_timeout   = timeout_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: a cycle-level behavioural model checked on
// every falling edge, plus hand-computed literal checks in the stimulus.
module tb_stall_ctrl;

  localparam int MC_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_mem = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_waddr = '0;
  logic        id_rs_ren = 1'b0, id_rt_ren = 1'b0, ex_load = 1'b0;
  logic        mc_req = 1'b0, mc_ready = 1'b0;
  logic [5:0]  stall;
  logic        mc_start, mc_busy, load_use, mc_timeout;
  logic [31:0] stall_cycles;

  int n_vec = 0;
  int n_err = 0;

  stall_ctrl #(.STALL_W(6), .MC_TIMEOUT(MC_TIMEOUT), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stallreq_mem(stallreq_mem),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_ren(id_rs_ren), .id_rt_ren(id_rt_ren),
    .ex_load(ex_load), .ex_waddr(ex_waddr), .mc_req(mc_req), .mc_ready(mc_ready),
    .stall(stall), .mc_start(mc_start), .mc_busy(mc_busy), .load_use(load_use),
    .mc_timeout(mc_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: an op is "waiting" from launch until ready/expiry, then "finished"
  // until it is allowed to leave EX.
  bit          m_waiting, m_finished, m_timeout;
  int          m_waited;
  logic [31:0] m_cycles = '0;
  logic        e_load_use, e_launch, e_busy;
  logic [5:0]  e_stall;

  always_comb begin
    e_load_use = rst && ex_load && ex_waddr != 0 &&
                 ((id_rs_ren && id_rs == ex_waddr) || (id_rt_ren && id_rt == ex_waddr));
    e_launch   = rst && !m_waiting && !m_finished && mc_req && !stallreq_mem;
    e_busy     = rst && m_waiting;
    if (!rst)                       e_stall = 6'h00;
    else if (stallreq_mem)          e_stall = 6'h1f;
    else if (m_waiting || e_launch) e_stall = 6'h0f;
    else if (e_load_use)            e_stall = 6'h07;
    else                            e_stall = 6'h00;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_waiting = 0; m_finished = 0; m_timeout = 0; m_waited = 0; m_cycles = '0;
    end else begin
      if (e_stall != 0) m_cycles = m_cycles + 1;
      if (e_launch) begin
        m_waiting = 1;
        m_waited  = 0;
      end else if (m_waiting) begin
        m_waited++;
        if (mc_ready) begin
          m_waiting = 0; m_finished = 1;
        end else if (m_waited == MC_TIMEOUT) begin
          m_waiting = 0; m_finished = 1; m_timeout = 1;
        end
      end else if (m_finished && !stallreq_mem) begin
        m_finished = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("stall",        {26'd0, stall},   {26'd0, e_stall});
    chk("mc_start",     {31'd0, mc_start}, {31'd0, e_launch});
    chk("mc_busy",      {31'd0, mc_busy},  {31'd0, e_busy});
    chk("load_use",     {31'd0, load_use}, {31'd0, e_load_use});
    chk("mc_timeout",   {31'd0, mc_timeout}, {31'd0, m_timeout});
    chk("stall_cycles", stall_cycles, m_cycles);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc(); rst = 1'b0;
    cyc(); rst = 1'b1;
  endtask

  task automatic clear_ld();
    ex_load = 0; ex_waddr = 0; id_rs = 0; id_rt = 0; id_rs_ren = 0; id_rt_ren = 0;
  endtask

  initial begin
    int busy_cnt;
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int start_cnt;
    // Reset state
    #3;
    chk("rst_stall", {26'd0, stall}, 32'h0);
    chk("rst_cnt", stall_cycles, 32'd0);
    chk("rst_timeout", {31'd0, mc_timeout}, 32'd0);
    cyc(); cyc(); rst = 1'b1;

    // Load-use hazards
    cyc(); ex_load = 1; ex_waddr = 8; id_rs = 8; id_rs_ren = 1; #2;
    chk("lu_rs_stall", {26'd0, stall}, 32'h07);
    chk("lu_rs_flag", {31'd0, load_use}, 32'd1);
    cyc(); ex_waddr = 0; id_rs = 0; #2;
    chk("lu_r0_stall", {26'd0, stall}, 32'h00);
    chk("lu_r0_flag", {31'd0, load_use}, 32'd0);
    cyc(); ex_waddr = 3; id_rt = 3; id_rt_ren = 1; id_rs_ren = 0; id_rs = 3; #2;
    chk("lu_rt_stall", {26'd0, stall}, 32'h07);
    cyc(); id_rt_ren = 0; #2;
    chk("lu_noren", {31'd0, load_use}, 32'd0);
    cyc(); ex_load = 0; id_rt_ren = 1; #2;
    chk("lu_noload", {31'd0, load_use}, 32'd0);
    clear_ld();

    // MC handshake: ready five cycles after the launch
    do_reset();
    cyc(); mc_req = 1; #2;
    chk("hs_start", {31'd0, mc_start}, 32'd1);
    chk("hs_stall0", {26'd0, stall}, 32'h0f);
    start_cnt = 1;
    for (int k = 1; k <= 5; k++) begin
      cyc(); if (k == 5) mc_ready = 1; #2;
      if (mc_start) start_cnt++;
      chk("hs_stall", {26'd0, stall}, 32'h0f);
      chk("hs_busy", {31'd0, mc_busy}, 32'd1);
    end
    cyc(); mc_ready = 0; #2;
    chk("hs_done_stall", {26'd0, stall}, 32'h00);
    chk("hs_done_cnt", stall_cycles, 32'd6);
    chk("hs_done_start", {31'd0, mc_start}, 32'd0);
    chk("hs_start_cnt", start_cnt, 32'd1);
    cyc(); mc_req = 0; #2;
    chk("hs_idle_stall", {26'd0, stall}, 32'h00);

    // Timeout with no ready
    do_reset();
    cyc(); mc_req = 1; #2;
    chk("to_start", {31'd0, mc_start}, 32'd1);
    busy_cnt = 0;
    for (int k = 1; k <= MC_TIMEOUT; k++) begin
      cyc(); #2;
      if (mc_busy) busy_cnt++;
    end
    chk("to_pre_flag", {31'd0, mc_timeout}, 32'd0);
    chk("to_busy_cnt", busy_cnt, MC_TIMEOUT);
    cyc(); #2;
    chk("to_flag", {31'd0, mc_timeout}, 32'd1);
    chk("to_done_busy", {31'd0, mc_busy}, 32'd0);
    chk("to_done_stall", {26'd0, stall}, 32'h00);
    cyc(); mc_req = 0; cyc(); #2;
    chk("to_sticky", {31'd0, mc_timeout}, 32'd1);

    // Ready on the final timer cycle wins
    do_reset();
    cyc(); mc_req = 1;
    for (int k = 1; k <= MC_TIMEOUT; k++) begin
      cyc(); if (k == MC_TIMEOUT) mc_ready = 1;
    end
    cyc(); mc_ready = 0; #2;
    chk("tr_flag", {31'd0, mc_timeout}, 32'd0);
    chk("tr_busy", {31'd0, mc_busy}, 32'd0);
    cyc(); mc_req = 0;

    // Priority, DONE hold, back-to-back launch
    do_reset();
    cyc(); mc_req = 1;
    cyc(); stallreq_mem = 1; ex_load = 1; ex_waddr = 5; id_rs = 5; id_rs_ren = 1; #2;
    chk("pr_mem", {26'd0, stall}, 32'h1f);
    chk("pr_lu", {31'd0, load_use}, 32'd1);
    cyc(); stallreq_mem = 0; #2;
    chk("pr_mc", {26'd0, stall}, 32'h0f);
    cyc(); clear_ld(); mc_ready = 1; stallreq_mem = 1; #2;
    chk("dh_ready_stall", {26'd0, stall}, 32'h1f);
    start_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(); mc_ready = 0; #2;
      if (mc_start) start_cnt++;
      chk("dh_hold_busy", {31'd0, mc_busy}, 32'd0);
      chk("dh_hold_stall", {26'd0, stall}, 32'h1f);
    end
    chk("dh_no_restart", start_cnt, 32'd0);
    cyc(); stallreq_mem = 0; #2;
    chk("dh_release_start", {31'd0, mc_start}, 32'd0);
    chk("dh_release_stall", {26'd0, stall}, 32'h00);
    cyc(); #2;
    chk("dh_relaunch", {31'd0, mc_start}, 32'd1);

    // Asynchronous reset mid-BUSY
    cyc(); #2;
    chk("ar_pre_busy", {31'd0, mc_busy}, 32'd1);
    rst = 0; #1;
    chk("ar_stall", {26'd0, stall}, 32'h00);
    chk("ar_busy", {31'd0, mc_busy}, 32'd0);
    chk("ar_start", {31'd0, mc_start}, 32'd0);
    cyc(); rst = 1; mc_req = 0;
    cyc(); mc_ready = 1; #2;
    chk("ar_stray_stall", {26'd0, stall}, 32'h00);
    chk("ar_stray_busy", {31'd0, mc_busy}, 32'd0);
    cyc(); mc_ready = 0; #2;
    chk("ar_after_stall", {26'd0, stall}, 32'h00);
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stall_ctrl.md
Name: stall_ctrl

Overview:
- Central pipeline stall controller for the 5-stage core (PC/IF/ID/EX/MEM/WB).
- Detects load-use hazards that ID forwarding cannot cover, sequences multi-cycle EX operations (mul/div) through a req/ready handshake, and merges the memory-wait request.
- Produces the shared stall bus consumed by every stage register. A stage inserts a bubble when its own stall bit is Stop and the next stage's bit is NoStop.

Parameters:
- STALL_W, 6, stall bus width; bit0=PC, bit1=IF, bit2=ID, bit3=EX, bit4=MEM, bit5=WB.
- MC_TIMEOUT, 64, maximum BUSY cycles before the MC wait is abandoned.
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stallreq_mem  in  1  data/inst SRAM not ready; freezes through MEM.
- id_rs  in  5  rs field of instruction in ID.
- id_rt  in  5  rt field of instruction in ID.
- id_rs_ren  in  1  ID instruction reads rs.
- id_rt_ren  in  1  ID instruction reads rt.
- ex_load  in  1  instruction in EX is a load.
- ex_waddr  in  5  destination register of the EX instruction.
- mc_req  in  1  EX holds a multi-cycle op; level, held while the op sits in EX.
- mc_ready  in  1  multi-cycle unit result valid; 1-cycle pulse.
- stall  out  STALL_W  stall bus; 1=Stop.
- mc_start  out  1  1-cycle launch pulse to the multi-cycle unit.
- mc_busy  out  1  FSM in BUSY.
- load_use  out  1  load-use hazard detected this cycle.
- mc_timeout  out  1  sticky; set when a BUSY wait expires.
- stall_cycles  out  CNT_W  count of cycles with stall!=0.

Behaviour:
- Reset (rst=0, async): FSM=IDLE, timer=0, mc_timeout=0, stall_cycles=0. While in reset: stall=0, mc_start=0, mc_busy=0, load_use=0.
- load_use (combinational) = ex_load & ex_waddr!=0 & ((id_rs_ren & id_rs==ex_waddr) | (id_rt_ren & id_rt==ex_waddr)).
- FSM states: IDLE, BUSY, DONE. State is registered; all outputs are combinational from state and inputs (0-cycle latency).
- IDLE:
  - If mc_req & ~stallreq_mem: mc_start=1 this cycle, next state BUSY, timer<=0.
  - mc_ready is ignored in IDLE.
- BUSY:
  - mc_busy=1; timer increments each cycle.
  - If mc_ready: next state DONE.
  - Else if timer==MC_TIMEOUT-1: mc_timeout<=1, next state DONE.
  - mc_ready and timeout in the same cycle: treat as ready; mc_timeout is not set.
- DONE: the EX op advances this cycle.
  - If stallreq_mem=1: stay in DONE, so the still-present mc_req is not relaunched.
  - Otherwise next state IDLE. A back-to-back mc_req is seen in IDLE the following cycle.
- MC stall condition (mc_stall) is true when in BUSY, or in IDLE with the launch condition met.
- Stall priority, highest first:
  - stallreq_mem: 6'b011111, WB bubble.
  - mc_stall: 6'b001111, MEM bubble.
  - load_use: 6'b000111, EX bubble.
  - Otherwise: 6'b000000.
- Simultaneous requests produce the pattern of the highest-priority request only. That pattern is a superset, so the lower request is re-evaluated next cycle.
- load_use needs no state. After one bubble the load is in MEM and its value is forwarded. load_use is reported even when masked by a higher-priority stall.
- stall_cycles increments when stall!=0 and wraps modulo 2^CNT_W.
- mc_timeout is cleared only by reset.
- Reset asserted mid-BUSY returns the FSM to IDLE immediately and drops all stall bits. A mc_ready arriving after reset is ignored (IDLE).

Test Plan:
- Load-use: ex_load=1, ex_waddr=8, id_rs=8, id_rs_ren=1 -> stall=6'b000111, load_use=1 for that cycle. Same stimulus with ex_waddr=0 -> stall=0, load_use=0.
- MC handshake: mc_req=1 held, mc_ready pulses 5 cycles after mc_start:
  - mc_start=1 exactly one cycle; stall=6'b001111 for 6 cycles.
  - DONE cycle has stall=0; stall_cycles=6.
- Timeout: mc_req=1, mc_ready never asserted -> mc_busy high 64 cycles, then mc_timeout=1 and FSM reaches DONE. mc_ready and final timer cycle together -> mc_timeout stays 0.
- Priority: stallreq_mem=1 with BUSY and load_use active -> stall=6'b011111. Drop stallreq_mem -> 6'b001111.
- DONE hold: mc_ready with stallreq_mem=1 for 3 cycles and mc_req still high -> FSM stays DONE, no second mc_start. After release -> IDLE, and a new mc_req gives mc_start one cycle later.
- Async reset: rst=0 mid-BUSY (between clock edges) -> stall=0, mc_busy=0 immediately. After release, a stray mc_ready pulse causes no stall.
